isa_cycle_master: RTL
=====================

Name: isa_cycle_master

Overview:
- Bus initiator for the on-chip ISA-style bus. It drives the same strobes that the CGA and other peripheral blocks sample.
- Accepts single-byte IO/memory read/write requests from the CPU-side logic over a valid/ready handshake.
- Sequences address setup, the command strobe, wait states from bus_rdy, and hold. Returns read data with a one-cycle response pulse.
- Sits between the CPU core glue and all ISA responders (video, timers, keyboard) in the same clk domain.

Parameters:
- T_SETUP, 2, clk cycles address/data valid before command strobe asserts (range 1..15)
- T_STROBE, 4, minimum clk cycles strobe held low before bus_rdy is honoured (range 1..15)
- T_HOLD, 1, clk cycles address/data held after strobe deasserts (range 0..15)
- RDY_TIMEOUT, 255, max clk cycles of bus_rdy low after T_STROBE before forced termination (1..255)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block idle, request accepted when req_valid&req_ready
- req_write  in  1  1=write, 0=read
- req_io  in  1  1=IO cycle, 0=memory cycle
- req_addr  in  20  byte address; IO cycles use [15:0], upper bits driven 0
- req_wdata  in  8  write data
- rsp_valid  out  1  one-cycle pulse at cycle completion (reads and writes)
- rsp_rdata  out  8  read data, valid with rsp_valid
- rsp_timeout  out  1  completion was forced by timeout, valid with rsp_valid
- bus_a  out  20  ISA address
- bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l  out  1 each  active-low commands
- bus_d  out  8  write data to responders
- bus_d_oe  out  1  initiator driving bus_d
- bus_din  in  8  read data from responder mux
- bus_aen  out  1  DMA address enable; held 0 by this block
- bus_rdy  in  1  responder ready; low inserts wait states

Behaviour:
- Reset values:
  - all four command strobes 1
  - bus_a=0, bus_d=0, bus_d_oe=0, bus_aen=0
  - req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_timeout=0
  - FSM in IDLE, all counters 0
- Reset mid-cycle aborts immediately: strobes deassert the next edge and no rsp_valid is issued.
- All outputs are registered.
- FSM states: IDLE, SETUP, STROBE, WAIT, HOLD, DONE.
- IDLE
  - req_ready=1.
  - On handshake: latch addr/write/io/wdata; drive bus_a; bus_d_oe=req_write; req_ready->0; counter=T_SETUP-1; go SETUP.
- SETUP
  - Counts down. At 0: assert the selected strobe (io&~write->ior, io&write->iow, ~io&~write->memr, ~io&write->memw); counter=T_STROBE-1; go STROBE.
- STROBE
  - Counts down.
  - At 0: if bus_rdy=1, go HOLD; else reset timeout counter, go WAIT.
  - bus_rdy is ignored before the count reaches 0.
- WAIT
  - bus_rdy=1 -> HOLD.
  - Timeout counter reaching RDY_TIMEOUT -> set timeout flag, go HOLD.
- Transition into HOLD (same edge):
  - Strobe deasserts.
  - For reads, rsp_rdata captures bus_din sampled on that edge; on timeout, rsp_rdata=8'hFF.
  - counter=T_HOLD; with T_HOLD=0, go straight to DONE.
- HOLD
  - Counts down with address/data unchanged. At 0 go DONE.
- DONE
  - rsp_valid=1 for exactly one cycle; rsp_timeout=flag.
  - bus_d_oe=0; bus_a retains its last value; req_ready=1 next cycle; go IDLE.
- Writes: rsp_rdata holds its previous value.
- Back-to-back cycles: minimum gap is 1 IDLE cycle, during which all strobes are high.
- Exactly one strobe may be low at any time; never two.
- Latency with defaults and bus_rdy=1, handshake edge to rsp_valid: T_SETUP+T_STROBE+T_HOLD+1 = 8 cycles.
- Inputs changing after acceptance have no effect.

Decomposition:
- Shared package isa_pkg:
  - FSM state encoding (3-bit localparams)
  - command select encoding {io,write}
  - timing defaults and the 8'hFF timeout read value
- No sub-module is needed. The timing counter is a single 4-bit down-counter plus an 8-bit timeout counter inside the FSM.

Test Plan:
- Reset, then IO write to 0x3D8 data 0x29, bus_rdy=1:
  - bus_iow_l low for exactly 4 cycles, starting 2 cycles after acceptance.
  - bus_a=0x003D8 and bus_d=0x29 throughout.
  - rsp_valid 8 cycles after handshake; rsp_timeout=0.
- IO read from 0x3DA with bus_din=0xF9:
  - bus_ior_l low 4 cycles, bus_d_oe=0.
  - rsp_rdata=0xF9, rsp_valid once.
- Memory write 0xB8000 with bus_rdy held low 10 cycles after strobe start:
  - bus_memw_l low for 10 cycles, deasserting the edge after bus_rdy rises.
  - rsp_timeout=0.
- Memory read with bus_rdy stuck low, RDY_TIMEOUT=255:
  - Forced termination 4+255 cycles after strobe assertion.
  - rsp_rdata=0xFF, rsp_timeout=1.
- Back-to-back requests, req_valid held high with 4 queued ops:
  - One IDLE cycle between strobes; never two strobes low.
  - 4 rsp_valid pulses, in order.
- Assert reset during STROBE of a read:
  - Strobe high the next cycle, no rsp_valid, req_ready=1.
  - A subsequent request completes normally.

Source files
------------

// File: rtl/isa_pkg.sv
// Shared definitions for the ISA bus initiator: FSM encoding, command
// select encoding, timing defaults and the forced-timeout read value.
package isa_pkg;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETUP  = 3'd1;
    localparam logic [2:0] S_STROBE = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_HOLD   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    typedef enum logic [2:0] {
        IDLE   = S_IDLE,
        SETUP  = S_SETUP,
        STROBE = S_STROBE,
        WAIT   = S_WAIT,
        HOLD   = S_HOLD,
        DONE   = S_DONE
    } state_t;

    // Command select is {io, write}
    localparam logic [1:0] CMD_MEMR = 2'b00;
    localparam logic [1:0] CMD_MEMW = 2'b01;
    localparam logic [1:0] CMD_IOR  = 2'b10;
    localparam logic [1:0] CMD_IOW  = 2'b11;

    localparam int T_SETUP_DEF     = 2;
    localparam int T_STROBE_DEF    = 4;
    localparam int T_HOLD_DEF      = 1;
    localparam int RDY_TIMEOUT_DEF = 255;

    localparam logic [7:0] TIMEOUT_RDATA = 8'hFF;

    // Active-low strobe vector {ior, iow, memr, memw} for a command
    function automatic logic [3:0] cmd_strobes(input logic [1:0] cmd);
        logic [3:0] s;
        s = 4'hF;
        unique case (cmd)
            CMD_IOR:  s = 4'b0111;
            CMD_IOW:  s = 4'b1011;
            CMD_MEMR: s = 4'b1101;
            CMD_MEMW: s = 4'b1110;
            default:  s = 4'hF;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/isa_cycle_master.sv
// ISA bus initiator: runs one byte IO/memory cycle per accepted request.
// Ports: req_* handshake in, rsp_* completion out, bus_* ISA strobes/data.
module isa_cycle_master
    import isa_pkg::*;
#(
    parameter int T_SETUP     = T_SETUP_DEF,
    parameter int T_STROBE    = T_STROBE_DEF,
    parameter int T_HOLD      = T_HOLD_DEF,
    parameter int RDY_TIMEOUT = RDY_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic        req_io,
    input  logic [19:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_timeout,
    output logic [19:0] bus_a,
    output logic        bus_ior_l,
    output logic        bus_iow_l,
    output logic        bus_memr_l,
    output logic        bus_memw_l,
    output logic [7:0]  bus_d,
    output logic        bus_d_oe,
    input  logic [7:0]  bus_din,
    output logic        bus_aen,
    input  logic        bus_rdy
);

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [7:0]  tcnt, tcnt_n;
    logic        to_flag, to_n;
    logic [1:0]  cmd, cmd_n;
    logic [3:0]  strb, strb_n;
    logic [19:0] a_n;
    logic [7:0]  d_n, rd_n;
    logic        oe_n, ready_n, rv_n, rto_n;
    logic        go_hold, hold_to, go_done;

    assign {bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l} = strb;
    assign bus_aen = 1'b0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            tcnt        <= '0;
            to_flag     <= 1'b0;
            cmd         <= '0;
            strb        <= 4'hF;
            bus_a       <= '0;
            bus_d       <= '0;
            bus_d_oe    <= 1'b0;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            tcnt        <= tcnt_n;
            to_flag     <= to_n;
            cmd         <= cmd_n;
            strb        <= strb_n;
            bus_a       <= a_n;
            bus_d       <= d_n;
            bus_d_oe    <= oe_n;
            req_ready   <= ready_n;
            rsp_valid   <= rv_n;
            rsp_rdata   <= rd_n;
            rsp_timeout <= rto_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        tcnt_n  = tcnt;
        to_n    = to_flag;
        cmd_n   = cmd;
        strb_n  = strb;
        a_n     = bus_a;
        d_n     = bus_d;
        oe_n    = bus_d_oe;
        ready_n = req_ready;
        rv_n    = 1'b0;
        rd_n    = rsp_rdata;
        rto_n   = rsp_timeout;
        go_hold = 1'b0;
        hold_to = 1'b0;
        go_done = 1'b0;

        unique case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    cmd_n   = {req_io, req_write};
                    a_n     = req_io ? {4'h0, req_addr[15:0]} : req_addr;
                    d_n     = req_wdata;
                    oe_n    = req_write;
                    ready_n = 1'b0;
                    cnt_n   = 4'(T_SETUP - 1);
                    tcnt_n  = '0;
                    to_n    = 1'b0;
                    state_n = SETUP;
                end
            end
            SETUP: begin
                if (cnt == 4'd0) begin
                    strb_n  = cmd_strobes(cmd);
                    cnt_n   = 4'(T_STROBE - 1);
                    state_n = STROBE;
                end else begin
                    cnt_n = cnt - 4'd1;
                end
            end
            STROBE: begin
                // bus_rdy only matters once the minimum strobe time is met
                if (cnt != 4'd0) begin
                    cnt_n = cnt - 4'd1;
                end else if (bus_rdy) begin
                    go_hold = 1'b1;
                end else begin
                    tcnt_n  = '0;
                    state_n = WAIT;
                end
            end
            WAIT: begin
                if (bus_rdy) begin
                    go_hold = 1'b1;
                end else if (tcnt == 8'(RDY_TIMEOUT - 1)) begin
                    go_hold = 1'b1;
                    hold_to = 1'b1;
                end else begin
                    tcnt_n = tcnt + 8'd1;
                end
            end
            HOLD: begin
                if (cnt == 4'd0) go_done = 1'b1;
                else cnt_n = cnt - 4'd1;
            end
            DONE: begin
                ready_n = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        if (go_hold) begin
            strb_n = 4'hF;
            to_n   = hold_to;
            if (!cmd[0]) rd_n = hold_to ? TIMEOUT_RDATA : bus_din;
            cnt_n  = 4'(T_HOLD);
            if (T_HOLD == 0) go_done = 1'b1;
            else state_n = HOLD;
        end

        if (go_done) begin
            rv_n    = 1'b1;
            rto_n   = to_n;
            oe_n    = 1'b0;
            state_n = DONE;
        end
    end

endmodule
